// File: rtl/icache_sa.sv
// icache_sa: blocking set-associative instruction cache with full-line L2 refill, FENCE.I flush and hit/miss counters
module icache_sa #(
    parameter int INSTR_WIDTH = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int LINE_SIZE   = 64,
    parameter int WAYS        = 2,
    parameter int IMEM_SIZE   = 16384
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     icache_flush_i,
    input  logic                     cpu_req_valid_i,
    input  logic [ADDR_WIDTH-1:0]    cpu_addr_i,
    output logic                     icache_req_ready_o,
    output logic                     icache_resp_valid_o,
    output logic [INSTR_WIDTH-1:0]   icache_resp_instr_o,
    input  logic                     cpu_resp_ready_i,
    output logic                     l2_req_valid_o,
    output logic [ADDR_WIDTH-1:0]    l2_req_addr_o,
    input  logic                     l2_req_ready_i,
    input  logic                     l2_resp_valid_i,
    input  logic [LINE_SIZE*8-1:0]   l2_data_i,
    output logic [31:0]              hit_count_o,
    output logic [31:0]              miss_count_o,
    output logic                     flush_busy_o
);
    localparam int SETS   = IMEM_SIZE / (WAYS * LINE_SIZE);
    localparam int OFFSET = $clog2(LINE_SIZE);
    localparam int INDEX  = $clog2(SETS);
    localparam int TAG    = ADDR_WIDTH - OFFSET - INDEX;
    localparam int WB     = $clog2(INSTR_WIDTH / 8);
    localparam int LB     = LINE_SIZE * 8;
    localparam int RW     = WAYS > 1 ? $clog2(WAYS) : 1;

    typedef enum logic [2:0] {IDLE, LOOKUP, REFILL_REQ, REFILL_WAIT, RESP, FLUSH} state_t;

    state_t state, state_n;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [WAYS-1:0][SETS-1:0] valid_q;
    logic [SETS-1:0][RW-1:0] rr_q;
    logic [TAG-1:0] tag_q [WAYS][SETS];
    logic [LB-1:0] data_q [WAYS][SETS];
    logic [RW-1:0] victim, victim_q;
    logic [LB-1:0] hit_line;
    logic [INSTR_WIDTH-1:0] instr_q;
    logic [31:0] hit_cnt, miss_cnt;
    logic hit, full, evict_q, flush_pending, accept, refill;
    logic [TAG-1:0] ltag;
    logic [INDEX-1:0] lidx;

    function automatic logic [INSTR_WIDTH-1:0] pick(input logic [LB-1:0] l, input logic [OFFSET-1:0] o);
        logic [INSTR_WIDTH-1:0] r;
        r = '0;
        for (int k = 0; k < LB / INSTR_WIDTH; k++)
            if ((o >> WB) == OFFSET'(k)) r = l[k*INSTR_WIDTH +: INSTR_WIDTH];
        return r;
    endfunction

    assign ltag   = addr_q[ADDR_WIDTH-1 -: TAG];
    assign lidx   = addr_q[OFFSET +: INDEX];
    assign accept = icache_req_ready_o && cpu_req_valid_i;
    assign refill = state == REFILL_WAIT && l2_resp_valid_i;

    // a flush arriving with a request in IDLE wins, so it also blocks acceptance
    assign icache_req_ready_o  = state == IDLE && !flush_pending && !icache_flush_i && !rst_i;
    assign icache_resp_valid_o = state == RESP;
    assign icache_resp_instr_o = instr_q;
    assign l2_req_valid_o      = state == REFILL_REQ;
    assign l2_req_addr_o       = l2_req_valid_o ? {addr_q[ADDR_WIDTH-1:OFFSET], {OFFSET{1'b0}}} : '0;
    assign hit_count_o         = hit_cnt;
    assign miss_count_o        = miss_cnt;
    assign flush_busy_o        = flush_pending || state == FLUSH;

    // lowest-numbered invalid way is preferred; the round-robin pointer only applies to a full set
    always_comb begin
        hit      = 1'b0;
        hit_line = '0;
        full     = 1'b1;
        victim   = rr_q[lidx];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[w][lidx] && tag_q[w][lidx] == ltag) begin
                hit      = 1'b1;
                hit_line = data_q[w][lidx];
            end
            if (!valid_q[w][lidx]) begin
                full   = 1'b0;
                victim = RW'(w);
            end
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:        state_n = flush_pending ? FLUSH : accept ? LOOKUP : IDLE;
            LOOKUP:      state_n = hit ? RESP : REFILL_REQ;
            REFILL_REQ:  state_n = l2_req_ready_i ? REFILL_WAIT : REFILL_REQ;
            REFILL_WAIT: state_n = l2_resp_valid_i ? RESP : REFILL_WAIT;
            RESP:        state_n = cpu_resp_ready_i ? IDLE : RESP;
            FLUSH:       state_n = IDLE;
            default:     state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= IDLE;
            addr_q        <= '0;
            valid_q       <= '0;
            rr_q          <= '0;
            victim_q      <= '0;
            evict_q       <= 1'b0;
            instr_q       <= '0;
            hit_cnt       <= '0;
            miss_cnt      <= '0;
            flush_pending <= 1'b0;
        end else begin
            state         <= state_n;
            flush_pending <= icache_flush_i || (flush_pending && state != FLUSH);
            if (accept) addr_q <= cpu_addr_i;
            if (state == LOOKUP && hit) begin
                instr_q <= pick(hit_line, addr_q[OFFSET-1:0]);
                hit_cnt <= hit_cnt != '1 ? hit_cnt + 32'd1 : hit_cnt;
            end
            if (state == LOOKUP && !hit) begin
                miss_cnt <= miss_cnt != '1 ? miss_cnt + 32'd1 : miss_cnt;
                victim_q <= victim;
                evict_q  <= full;
            end
            if (refill) begin
                valid_q[victim_q][lidx] <= 1'b1;
                instr_q                 <= pick(l2_data_i, addr_q[OFFSET-1:0]);
                if (evict_q) rr_q[lidx] <= WAYS == 1 ? '0 : rr_q[lidx] + 1'b1;
            end
            if (state == FLUSH) valid_q <= '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (refill && !rst_i) begin
            tag_q[victim_q][lidx]  <= ltag;
            data_q[victim_q][lidx] <= l2_data_i;
        end
    end
endmodule

// File: tb/tb_icache_sa.sv
// tb_icache_sa: table-driven fetch sequences with an L2 line model and a response scoreboard
module tb_icache_sa;
    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    logic icache_flush_i = 1'b0;
    logic cpu_req_valid_i = 1'b0;
    logic [31:0] cpu_addr_i = '0;
    logic icache_req_ready_o;
    logic icache_resp_valid_o;
    logic [31:0] icache_resp_instr_o;
    logic cpu_resp_ready_i = 1'b0;
    logic l2_req_valid_o;
    logic [31:0] l2_req_addr_o;
    logic l2_req_ready_i = 1'b0;
    logic l2_resp_valid_i = 1'b0;
    logic [511:0] l2_data_i = '0;
    logic [31:0] hit_count_o, miss_count_o;
    logic flush_busy_o;

    icache_sa dut (
        .clk_i(clk_i), .rst_i(rst_i), .icache_flush_i(icache_flush_i),
        .cpu_req_valid_i(cpu_req_valid_i), .cpu_addr_i(cpu_addr_i),
        .icache_req_ready_o(icache_req_ready_o), .icache_resp_valid_o(icache_resp_valid_o),
        .icache_resp_instr_o(icache_resp_instr_o), .cpu_resp_ready_i(cpu_resp_ready_i),
        .l2_req_valid_o(l2_req_valid_o), .l2_req_addr_o(l2_req_addr_o),
        .l2_req_ready_i(l2_req_ready_i), .l2_resp_valid_i(l2_resp_valid_i),
        .l2_data_i(l2_data_i), .hit_count_o(hit_count_o), .miss_count_o(miss_count_o),
        .flush_busy_o(flush_busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] a;
        bit          miss;
        int          ls;
        int          cs;
    } row_t;

    row_t tbl [11];
    logic [31:0] sb [$];
    int n_cmp = 0, n_bad = 0, l2_req_cnt = 0;
    logic [31:0] exp_hits = '0, exp_misses = '0;

    always @(posedge clk_i) if (l2_req_valid_o && l2_req_ready_i) l2_req_cnt <= l2_req_cnt + 1;

    function automatic logic [31:0] l2_word(input logic [31:0] la, input int k);
        return 32'hA000_0000 + ((la ^ 32'h1000) << 2) + 32'(k);
    endfunction

    function automatic logic [511:0] l2_line(input logic [31:0] la);
        logic [511:0] l;
        for (int k = 0; k < 16; k++) l[k*32 +: 32] = l2_word(la, k);
        return l;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic fetch(input logic [31:0] a, input bit miss, input int ls, input int cs, input bit fl);
        logic [31:0] la;
        int rq0;
        la  = {a[31:6], 6'b0};
        rq0 = l2_req_cnt;
        cpu_req_valid_i = 1'b1;
        cpu_addr_i      = a;
        for (int i = 0; i < 50 && !icache_req_ready_o; i++) tick();
        chk("req_ready", icache_req_ready_o, 1);
        sb.push_back(l2_word(la, int'(a[5:2])));
        tick();
        cpu_req_valid_i = 1'b0;
        cpu_addr_i      = $urandom;
        tick();
        chk("resp_at_2_cycles", icache_resp_valid_o, !miss);
        chk("l2_req_valid", l2_req_valid_o, miss);
        if (miss) begin
            for (int i = 0; i < ls; i++) begin
                tick();
                chk("l2_hold_valid", l2_req_valid_o, 1);
                chk("l2_hold_addr", l2_req_addr_o, la);
            end
            chk("l2_req_addr", l2_req_addr_o, la);
            l2_req_ready_i = 1'b1;
            tick();
            l2_req_ready_i = 1'b0;
            chk("l2_req_drop", l2_req_valid_o, 0);
            if (fl) icache_flush_i = 1'b1;
            tick();
            icache_flush_i = 1'b0;
            if (fl) chk("flush_busy_in_wait", flush_busy_o, 1);
            l2_resp_valid_i = 1'b1;
            l2_data_i       = l2_line(la);
            tick();
            l2_resp_valid_i = 1'b0;
            l2_data_i       = {16{$urandom}};
        end
        if (miss) exp_misses = exp_misses + (exp_misses != '1 ? 32'd1 : 32'd0);
        else exp_hits = exp_hits + (exp_hits != '1 ? 32'd1 : 32'd0);
        chk("hit_count", hit_count_o, exp_hits);
        chk("miss_count", miss_count_o, exp_misses);
        for (int i = 0; i < cs; i++) begin
            chk("resp_hold_valid", icache_resp_valid_o, 1);
            chk("resp_hold_instr", icache_resp_instr_o, sb[0]);
            tick();
        end
        chk("resp_valid", icache_resp_valid_o, 1);
        cpu_resp_ready_i = 1'b1;
        chk("resp_instr", icache_resp_instr_o, sb.pop_front());
        tick();
        cpu_resp_ready_i = 1'b0;
        chk("resp_done", icache_resp_valid_o, 0);
        chk("l2_req_count", 64'(l2_req_cnt - rq0), 64'(miss));
    endtask

    initial begin
        tbl[0]  = '{32'h0000_1000, 1'b1, 0, 0};
        tbl[1]  = '{32'h0000_1008, 1'b0, 0, 0};
        tbl[2]  = '{32'h0000_0000, 1'b1, 0, 0};
        tbl[3]  = '{32'h0000_2000, 1'b1, 0, 0};
        tbl[4]  = '{32'h0000_4000, 1'b1, 0, 0};
        tbl[5]  = '{32'h0000_2004, 1'b0, 0, 0};
        tbl[6]  = '{32'h0000_0000, 1'b1, 0, 0};
        tbl[7]  = '{32'h0000_4008, 1'b0, 0, 0};
        tbl[8]  = '{32'h0000_2000, 1'b1, 0, 0};
        tbl[9]  = '{32'h0000_303C, 1'b1, 5, 3};
        tbl[10] = '{32'h0000_3000, 1'b0, 0, 2};

        repeat (3) tick();
        chk("ready_in_reset", icache_req_ready_o, 0);
        rst_i = 1'b0;
        tick();
        chk("rst_ready", icache_req_ready_o, 1);
        chk("rst_resp_valid", icache_resp_valid_o, 0);
        chk("rst_l2_valid", l2_req_valid_o, 0);
        chk("rst_hits", hit_count_o, 0);
        chk("rst_misses", miss_count_o, 0);
        chk("rst_flush_busy", flush_busy_o, 0);

        for (int i = 0; i < 11; i++) fetch(tbl[i].a, tbl[i].miss, tbl[i].ls, tbl[i].cs, 1'b0);

        // flush during refill of 0x1000 after 0x5000 pushes it out of set 64
        fetch(32'h0000_5000, 1'b1, 0, 0, 1'b0);
        fetch(32'h0000_1000, 1'b1, 1, 0, 1'b1);
        chk("pending_ready", icache_req_ready_o, 0);
        chk("pending_busy", flush_busy_o, 1);
        tick();
        chk("flush_ready", icache_req_ready_o, 0);
        chk("flush_busy", flush_busy_o, 1);
        tick();
        chk("post_flush_busy", flush_busy_o, 0);
        chk("post_flush_ready", icache_req_ready_o, 1);
        fetch(32'h0000_1000, 1'b1, 0, 0, 1'b0);
        fetch(32'h0000_2000, 1'b1, 0, 0, 1'b0);

        // flush and request together in IDLE: request must be dropped
        cpu_req_valid_i = 1'b1;
        cpu_addr_i      = 32'h0000_1004;
        icache_flush_i  = 1'b1;
        #1;
        chk("flush_wins_ready", icache_req_ready_o, 0);
        tick();
        icache_flush_i  = 1'b0;
        cpu_req_valid_i = 1'b0;
        chk("flush_wins_busy", flush_busy_o, 1);
        tick();
        chk("flush_wins_busy2", flush_busy_o, 1);
        tick();
        chk("flush_wins_idle", flush_busy_o, 0);
        chk("flush_wins_no_lookup", icache_resp_valid_o | l2_req_valid_o, 0);
        chk("flush_wins_misses", miss_count_o, exp_misses);
        fetch(32'h0000_1004, 1'b1, 0, 0, 1'b0);

        // reset while REFILL_REQ, then a stray L2 response
        cpu_req_valid_i = 1'b1;
        cpu_addr_i      = 32'h0000_0040;
        for (int i = 0; i < 50 && !icache_req_ready_o; i++) tick();
        chk("rr_req_ready", icache_req_ready_o, 1);
        tick();
        cpu_req_valid_i = 1'b0;
        tick();
        chk("rr_in_refill_req", l2_req_valid_o, 1);
        rst_i = 1'b1;
        #1;
        chk("rr_ready_in_reset", icache_req_ready_o, 0);
        tick();
        rst_i           = 1'b0;
        l2_resp_valid_i = 1'b1;
        l2_data_i       = l2_line(32'h0000_0040);
        tick();
        l2_resp_valid_i = 1'b0;
        chk("rr_resp_valid", icache_resp_valid_o, 0);
        chk("rr_l2_valid", l2_req_valid_o, 0);
        chk("rr_l2_addr", l2_req_addr_o, 0);
        chk("rr_instr", icache_resp_instr_o, 0);
        chk("rr_hits", hit_count_o, 0);
        chk("rr_misses", miss_count_o, 0);
        chk("rr_busy", flush_busy_o, 0);
        chk("rr_ready", icache_req_ready_o, 1);
        sb.delete();
        exp_hits   = '0;
        exp_misses = '0;
        fetch(32'h0000_0040, 1'b1, 0, 0, 1'b0);
        fetch(32'h0000_1000, 1'b1, 0, 0, 1'b0);

        // hit counter saturation
        force dut.hit_cnt = 32'hFFFF_FFFE;
        tick();
        release dut.hit_cnt;
        tick();
        exp_hits = 32'hFFFF_FFFE;
        chk("sat_preload", hit_count_o, exp_hits);
        fetch(32'h0000_0044, 1'b0, 0, 0, 1'b0);
        fetch(32'h0000_0048, 1'b0, 0, 0, 1'b0);
        chk("sat_hold", hit_count_o, 32'hFFFF_FFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/icache_sa.md
Name: icache_sa

Overview:
- Parametrised, blocking, set-associative instruction cache between the fetch unit and L2.
- Physically addressed; one outstanding miss at a time.
- Full-line refill from L2 over a valid/ready request and response pair.
- Victim choice: first invalid way, else a per-set round-robin pointer.
- Supports FENCE.I flush and exposes hit/miss performance counters.

Parameters:
- INSTR_WIDTH, 32, fetch word width in bits (multiple of 8).
- ADDR_WIDTH, 32, physical address width.
- LINE_SIZE, 64, line size in bytes (power of 2, ≥ INSTR_WIDTH/8).
- WAYS, 2, associativity (power of 2, ≥ 1).
- IMEM_SIZE, 16384, capacity in bytes.
- Derived: SETS = IMEM_SIZE/(WAYS*LINE_SIZE); OFFSET = clog2(LINE_SIZE); INDEX = clog2(SETS); TAG = ADDR_WIDTH-OFFSET-INDEX.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- icache_flush_i  in  1  FENCE.I invalidate request, single-cycle pulse.
- cpu_req_valid_i  in  1  fetch request valid.
- cpu_addr_i  in  ADDR_WIDTH  fetch physical address.
- icache_req_ready_o  out  1  cache accepts a request.
- icache_resp_valid_o  out  1  instruction valid.
- icache_resp_instr_o  out  INSTR_WIDTH  instruction word.
- cpu_resp_ready_i  in  1  CPU accepts the response.
- l2_req_valid_o  out  1  refill request valid.
- l2_req_addr_o  out  ADDR_WIDTH  line-aligned refill address; low OFFSET bits are 0.
- l2_req_ready_i  in  1  L2 accepts the refill request.
- l2_resp_valid_i  in  1  refill line valid (cache is always ready in REFILL_WAIT).
- l2_data_i  in  LINE_SIZE*8  refill line; byte 0 is at bits [7:0].
- hit_count_o  out  32  saturating hit counter.
- miss_count_o  out  32  saturating miss counter.
- flush_busy_o  out  1  flush pending or executing.

Behaviour:
- Reset (rst_i high at a clock edge):
  - State returns to IDLE; all valid bits and round-robin pointers cleared.
  - Counters cleared; pending flush cleared.
  - All outputs 0 except icache_req_ready_o, which is 0 during reset and 1 in the first IDLE cycle after.
  - Reset mid-miss abandons the refill; any later l2_resp_valid_i is ignored outside REFILL_WAIT.
- Address split: tag = [ADDR_WIDTH-1 : OFFSET+INDEX], index = [OFFSET+INDEX-1 : OFFSET], word select = offset >> clog2(INSTR_WIDTH/8).
  - Offset low bits below word granularity are ignored.
  - cpu_addr_i is registered on accept; later changes to cpu_addr_i have no effect.
- States: IDLE, LOOKUP, REFILL_REQ, REFILL_WAIT, RESP, FLUSH.
- IDLE:
  - icache_req_ready_o = !flush_pending.
  - If flush_pending, go to FLUSH.
  - Else if cpu_req_valid_i, latch the address and go to LOOKUP.
- LOOKUP:
  - Compare the tag against all ways of the set.
  - Hit: select the word, increment hit_count, go to RESP. Hit latency = 2 cycles from accept to icache_resp_valid_o.
  - Miss: increment miss_count, pick the victim way, go to REFILL_REQ.
- REFILL_REQ:
  - l2_req_valid_o = 1, l2_req_addr_o = {tag, index, 0}.
  - Valid and address are held stable until l2_req_ready_i, then go to REFILL_WAIT.
- REFILL_WAIT:
  - On l2_resp_valid_i: write data and tag to the victim way, set its valid bit, select the word from l2_data_i, go to RESP.
  - Advance the set's round-robin pointer (mod WAYS) only when a valid line was evicted.
- RESP:
  - icache_resp_valid_o = 1; icache_resp_instr_o is held stable until cpu_resp_ready_i.
  - Return to IDLE on the handshake. No back-to-back accept in the same cycle.
- Flush:
  - icache_flush_i in any state sets flush_pending.
  - FLUSH clears all valid bits in one cycle, clears flush_pending, and returns to IDLE.
  - A flush during a miss lets the refill and response complete first; the refilled line is then invalidated.
  - flush_busy_o = flush_pending or state==FLUSH.
  - Round-robin pointers are not reset by flush.
- Simultaneous flush and request in IDLE: the flush wins and the request is not accepted.
- Counters saturate at 2^32-1 and do not wrap.
- With WAYS=1, the victim is always way 0 and the pointer is unused.

Test Plan:
1. Reset, then fetch 0x0000_1000. Required: miss_count=1 and l2_req_addr_o=0x0000_1000. Return a line with word k = 0xA000_0000+k. Required: resp instr 0xA000_0000. Then fetch 0x0000_1008. Required: hit, instr 0xA000_0002 exactly 2 cycles after accept, hit_count=1.
2. Set 0 conflict: fill 0x0000_0000 and 0x0000_2000 (ways 0 and 1), then fetch 0x0000_4000. Required: evicts way 0. Then 0x0000_0000 misses and 0x0000_2000 hits.
3. Backpressure: hold l2_req_ready_i low for 5 cycles and cpu_resp_ready_i low for 3 cycles. Required: l2_req_valid_o/addr and icache_resp_valid_o/instr stay stable, exactly one L2 request is issued, and instr is unchanged.
4. Flush pulse in REFILL_WAIT for 0x0000_1000. Required: the response completes with correct data, then FLUSH; a later fetch of 0x0000_1000 misses (miss_count increments); icache_req_ready_o=0 while flush_busy_o=1.
5. Assert rst_i in REFILL_REQ, then assert l2_resp_valid_i the next cycle. Required: ignored; outputs at reset values; a subsequent fetch misses.
6. Force hit_count to 0xFFFF_FFFF (or run a long hit loop). Required: hit_count stays at 0xFFFF_FFFF after further hits.
